prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter: ADDR_W, 16, width of the instruction-memory address.
REQ-002 Parameter: BASE_ADDR, 0, memory address of the first loaded word.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 rx_data  input  8  received program byte.
REQ-006 rx_valid  input  1  one-cycle strobe; rx_data is valid; no backpressure.
REQ-007 restart  input  1  one-cycle pulse; re-arms the loader for a new frame.
REQ-008 mem_addr  output  ADDR_W  write address to instruction memory.
REQ-009 mem_wdata  output  32  write data to instruction memory.
REQ-010 mem_we  output  1  write enable, one cycle per word.
REQ-011 cpu_reset  output  1  active-high; holds the CPU in reset until load completes.
REQ-012 busy  output  1  frame reception in progress (length received, frame not finished).
REQ-013 done  output  1  frame loaded successfully.
REQ-014 error  output  1  frame rejected (checksum mismatch).
REQ-015 loaded_words  output  16  count of words written in the current frame.

Function
REQ-016 Frame format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then 4*N data bytes, each word big-endian; optional checksum byte per REQ-030.
REQ-017 FSM states: S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERR; state advances only on an rx_valid cycle, except as stated below.
REQ-018 S_LEN_HI -> S_LEN_LO on byte; S_LEN_LO -> S_DATA on byte if N != 0; if N == 0 -> S_CSUM (macro defined) or S_DONE (macro undefined).
REQ-019 S_DATA: 2-bit byte index; the 4th byte completes a word; the word is {b0,b1,b2,b3}.
REQ-020 mem_we is high exactly one cycle, the cycle after the 4th byte is accepted; mem_addr = BASE_ADDR + word index; mem_wdata = assembled word; both stable during mem_we.
REQ-021 Address arithmetic is modulo 2^ADDR_W (wraps silently); loaded_words increments in the same cycle as mem_we.
REQ-022 After the Nth word write: -> S_CSUM (macro defined) or S_DONE (macro undefined).
REQ-023 Back-to-back rx_valid on every cycle is supported with no byte loss.
REQ-024 cpu_reset = 1 in every state except S_DONE; done = 1 only in S_DONE; error = 1 only in S_ERR; busy = 1 in S_LEN_LO, S_DATA, S_CSUM.
REQ-025 In S_DONE and S_ERR, rx_valid is ignored.
REQ-026 restart in any state -> S_LEN_HI, clears byte index, word index, loaded_words and checksum; a pending mem_we is cancelled.
REQ-027 If restart and rx_valid occur in the same cycle, restart wins and the byte is dropped.

Reset
REQ-028 reset_n low, asynchronously: state = S_LEN_HI, mem_we = 0, mem_addr = BASE_ADDR, mem_wdata = 0, loaded_words = 0, cpu_reset = 1, busy = done = error = 0.
REQ-029 Reset asserted mid-frame discards the partial word; no write occurs.

Configuration
REQ-030 Macro PROG_LOADER_CSUM_EN, defined: the byte after the last data byte is a checksum equal to the XOR of all 4*N data bytes; on match -> S_DONE, on mismatch -> S_ERR. Memory writes already performed are not undone.
REQ-031 Macro PROG_LOADER_CSUM_EN, undefined: S_CSUM and S_ERR are unreachable; error is tied to 0.

Structure
REQ-032 Shared package osecpu_pkg holds the state enum, WORD_W = 32, and the default ADDR_W.
REQ-033 One sub-module, word_packer, performs the byte-to-word shift and index counting, with a word_ready strobe.

Verification
REQ-034 Frame 00 01 12 34 56 78 (+checksum 08 when the macro is defined) -> one write, addr 0x0000, data 0x12345678; then done = 1, cpu_reset = 0.
REQ-035 N = 3, bytes on every cycle -> three mem_we pulses at addr 0, 1, 2; loaded_words = 3; no gaps lost.
REQ-036 Macro defined, bad checksum -> error = 1, cpu_reset = 1, writes still present; then restart with a good frame -> done = 1.
REQ-037 N = 0 -> no write; S_DONE after LEN_LO (macro undefined) or after the checksum byte 00 (macro defined).
REQ-038 BASE_ADDR = 0xFFFF, N = 2 -> writes at 0xFFFF then 0x0000.
REQ-039 reset_n pulsed after 6 data bytes -> no further mem_we, outputs at reset values; restart asserted together with rx_valid -> byte dropped.

Source files
------------

// File: rtl/osecpu_pkg.sv
// Shared types and constants for the program loader block.
package osecpu_pkg;
  localparam int WORD_W     = 32;
  localparam int DEF_ADDR_W = 16;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;
endpackage

// File: rtl/prog_loader_if.sv
// Byte stream in, instruction-memory write port and loader status out.
interface prog_loader_if
  import osecpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              restart;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic              mem_we;
  logic              cpu_reset;
  logic              busy;
  logic              done;
  logic              error;
  logic [15:0]       loaded_words;

  modport master (
    output rx_data, rx_valid, restart,
    input  mem_addr, mem_wdata, mem_we, cpu_reset, busy, done, error, loaded_words
  );

  modport slave (
    input  rx_data, rx_valid, restart,
    output mem_addr, mem_wdata, mem_we, cpu_reset, busy, done, error, loaded_words
  );
endinterface

// File: rtl/prog_loader_word_packer.sv
// Shifts incoming bytes into a big-endian word; word_ready_o strobes
// combinationally with the 4th byte, word_o valid in that same cycle.
module word_packer
  import osecpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              byte_vld_i,
  input  logic [7:0]        byte_dat_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_ready_o
);
  logic [1:0]  idx_q, idx_d;
  logic [23:0] sh_q, sh_d;

  always_comb begin
    idx_d = idx_q;
    sh_d  = sh_q;
    if (clr_i) begin
      idx_d = '0;
      sh_d  = '0;
    end else if (byte_vld_i) begin
      idx_d = idx_q + 2'd1;
      sh_d  = {sh_q[15:0], byte_dat_i};
    end
  end

  assign word_o       = {sh_q, byte_dat_i};
  assign word_ready_o = byte_vld_i && !clr_i && (idx_q == 2'd3);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      sh_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sh_q  <= sh_d;
    end
  end
endmodule

// File: rtl/prog_loader.sv
// Loads a length-prefixed byte frame into instruction memory, holding the CPU in reset
// until done. Optional trailing XOR checksum enabled by macro PROG_LOADER_CSUM_EN.
module prog_loader
  import osecpu_pkg::*;
#(
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
)(
  input  logic         clk,
  input  logic         reset_n,
  prog_loader_if.slave bus
);
`ifdef PROG_LOADER_CSUM_EN
  localparam state_t FRAME_END = S_CSUM;
  logic [7:0] csum_q, csum_d;
`else
  localparam state_t FRAME_END = S_DONE;
`endif

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [15:0]       loaded_q, loaded_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] pk_word;
  logic              pk_ready;
  logic              pk_vld;

  assign pk_vld = bus.rx_valid && (state_q == S_DATA);

  word_packer u_packer (
    .clk          (clk),
    .reset_n      (reset_n),
    .clr_i        (bus.restart),
    .byte_vld_i   (pk_vld),
    .byte_dat_i   (bus.rx_data),
    .word_o       (pk_word),
    .word_ready_o (pk_ready)
  );

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    loaded_d = loaded_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    we_d     = 1'b0;
`ifdef PROG_LOADER_CSUM_EN
    csum_d   = csum_q;
`endif
    if (bus.restart) begin
      state_d  = S_LEN_HI;
      loaded_d = '0;
      addr_d   = BASE_ADDR;
`ifdef PROG_LOADER_CSUM_EN
      csum_d   = '0;
`endif
    end else begin
      // Write is registered, so it lands the cycle after the 4th byte.
      if (pk_ready) begin
        we_d     = 1'b1;
        wdata_d  = pk_word;
        addr_d   = BASE_ADDR + ADDR_W'(loaded_q);
        loaded_d = loaded_q + 16'd1;
      end
`ifdef PROG_LOADER_CSUM_EN
      if (pk_vld) csum_d = csum_q ^ bus.rx_data;
`endif
      case (state_q)
        S_LEN_HI: if (bus.rx_valid) begin
          len_d   = {bus.rx_data, 8'h00};
          state_d = S_LEN_LO;
        end
        S_LEN_LO: if (bus.rx_valid) begin
          len_d   = {len_q[15:8], bus.rx_data};
          state_d = ({len_q[15:8], bus.rx_data} == 16'd0) ? FRAME_END : S_DATA;
        end
        S_DATA: if (pk_ready && (loaded_q == len_q - 16'd1)) state_d = FRAME_END;
`ifdef PROG_LOADER_CSUM_EN
        S_CSUM: if (bus.rx_valid) state_d = (bus.rx_data == csum_q) ? S_DONE : S_ERR;
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_LEN_HI;
      len_q    <= '0;
      loaded_q <= '0;
      addr_q   <= BASE_ADDR;
      wdata_q  <= '0;
      we_q     <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      loaded_q <= loaded_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      we_q     <= we_d;
`ifdef PROG_LOADER_CSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  assign bus.mem_addr     = addr_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.mem_we       = we_q;
  assign bus.loaded_words = loaded_q;
  assign bus.cpu_reset    = (state_q != S_DONE);
  assign bus.done         = (state_q == S_DONE);
  assign bus.busy         = (state_q == S_LEN_LO) || (state_q == S_DATA) || (state_q == S_CSUM);
`ifdef PROG_LOADER_CSUM_EN
  assign bus.error        = (state_q == S_ERR);
`else
  assign bus.error        = 1'b0;
`endif
endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame table plus reset/restart corner sequences,
// with a second instance at BASE_ADDR 0xFFFF to cover address wrap.
module tb_prog_loader;
  import osecpu_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       restart = 1'b0;

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(16)) bus0 ();
  prog_loader_if #(.ADDR_W(16)) bus1 ();

  assign bus0.rx_data  = rx_data;
  assign bus0.rx_valid = rx_valid;
  assign bus0.restart  = restart;
  assign bus1.rx_data  = rx_data;
  assign bus1.rx_valid = rx_valid;
  assign bus1.restart  = restart;

  prog_loader #(.ADDR_W(16), .BASE_ADDR(16'h0000)) u0 (.clk(clk), .reset_n(reset_n), .bus(bus0.slave));
  prog_loader #(.ADDR_W(16), .BASE_ADDR(16'hFFFF)) u1 (.clk(clk), .reset_n(reset_n), .bus(bus1.slave));

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic [15:0] lw;
  } wr_t;

  wr_t q0[$];
  wr_t q1[$];

  always @(negedge clk) begin
    if (bus0.mem_we === 1'b1) q0.push_back({bus0.mem_addr, bus0.mem_wdata, bus0.loaded_words});
    if (bus1.mem_we === 1'b1) q1.push_back({bus1.mem_addr, bus1.mem_wdata, bus1.loaded_words});
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    restart  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
      restart  = 1'b0;
    end
  endtask

  task automatic do_restart();
    @(negedge clk);
    rx_valid = 1'b0;
    restart  = 1'b1;
    @(negedge clk);
    restart  = 1'b0;
  endtask

  // Bytes go out on consecutive cycles; the checksum byte is the XOR of the data bytes.
  task automatic send_frame(input logic [15:0] n, input logic [2:0][31:0] w, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    send(n[15:8]);
    send(n[7:0]);
    for (int i = 0; i < int'(n); i++) begin
      for (int j = 3; j >= 0; j--) begin
        b  = w[i][j*8 +: 8];
        cs = cs ^ b;
        send(b);
      end
    end
`ifdef PROG_LOADER_CSUM_EN
    send(bad ? ~cs : cs);
`else
    if (bad) cs = ~cs;
`endif
    idle(3);
  endtask

  typedef struct {
    logic [15:0]      n;
    logic [2:0][31:0] w;
    bit               bad;
    int               exp_loaded;
    logic             exp_done;
    logic             exp_err;
  } vec_t;

  vec_t tv[6];
  int   nvec;

  initial begin
    tv[0] = '{16'd1, {32'h0, 32'h0, 32'h12345678}, 1'b0, 1, 1'b1, 1'b0};
    tv[1] = '{16'd3, {32'hDEADBEEF, 32'hA5A5A5A5, 32'h11223344}, 1'b0, 3, 1'b1, 1'b0};
    tv[2] = '{16'd0, {32'h0, 32'h0, 32'h0}, 1'b0, 0, 1'b1, 1'b0};
    tv[3] = '{16'd2, {32'h0, 32'h00000001, 32'hCAFEF00D}, 1'b0, 2, 1'b1, 1'b0};
`ifdef PROG_LOADER_CSUM_EN
    tv[4] = '{16'd1, {32'h0, 32'h0, 32'h0F0F0F0F}, 1'b1, 1, 1'b0, 1'b1};
    tv[5] = '{16'd1, {32'h0, 32'h0, 32'h87654321}, 1'b0, 1, 1'b1, 1'b0};
    nvec  = 6;
`else
    nvec  = 4;
`endif

    #2 reset_n = 1'b0;
    #2;
    check("rst_we",     32'(bus0.mem_we),       32'd0);
    check("rst_addr",   32'(bus0.mem_addr),     32'h0000);
    check("rst_addr1",  32'(bus1.mem_addr),     32'hFFFF);
    check("rst_wdata",  bus0.mem_wdata,         32'd0);
    check("rst_loaded", 32'(bus0.loaded_words), 32'd0);
    check("rst_cpurst", 32'(bus0.cpu_reset),    32'd1);
    check("rst_busy",   32'(bus0.busy),         32'd0);
    check("rst_done",   32'(bus0.done),         32'd0);
    check("rst_error",  32'(bus0.error),        32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    for (int v = 0; v < nvec; v++) begin
      do_restart();
      q0.delete();
      q1.delete();
      send_frame(tv[v].n, tv[v].w, tv[v].bad);
      check($sformatf("v%0d_nwr", v),  32'(q0.size()), 32'(tv[v].n));
      check($sformatf("v%0d_nwr1", v), 32'(q1.size()), 32'(tv[v].n));
      for (int k = 0; k < int'(tv[v].n) && k < q0.size() && k < q1.size(); k++) begin
        logic [15:0] a1;
        a1 = 16'hFFFF + 16'(k);
        check($sformatf("v%0d_w%0d_addr", v, k),  32'(q0[k].addr), 32'(k));
        check($sformatf("v%0d_w%0d_data", v, k),  q0[k].data,      tv[v].w[k]);
        check($sformatf("v%0d_w%0d_lw", v, k),    32'(q0[k].lw),   32'(k + 1));
        check($sformatf("v%0d_w%0d_addr1", v, k), 32'(q1[k].addr), 32'(a1));
      end
      check($sformatf("v%0d_loaded", v), 32'(bus0.loaded_words), 32'(tv[v].exp_loaded));
      check($sformatf("v%0d_done", v),   32'(bus0.done),          32'(tv[v].exp_done));
      check($sformatf("v%0d_error", v),  32'(bus0.error),         32'(tv[v].exp_err));
      check($sformatf("v%0d_cpurst", v), 32'(bus0.cpu_reset),     32'(!tv[v].exp_done));
      check($sformatf("v%0d_busy", v),   32'(bus0.busy),          32'd0);
    end

    // Reset mid-frame: one word written, partial second word must never appear.
    do_restart();
    q0.delete();
    send(8'h00);
    idle(1);
    check("mid_busy_lenlo", 32'(bus0.busy), 32'd1);
    send(8'h02);
    for (int i = 1; i <= 6; i++) send(8'(i));
    idle(2);
    check("mid_nwr_pre",  32'(q0.size()),        32'd1);
    check("mid_busy",     32'(bus0.busy),        32'd1);
    check("mid_loaded",   32'(bus0.loaded_words), 32'd1);
    #1 reset_n = 1'b0;
    #2;
    check("mid_rst_we",     32'(bus0.mem_we),       32'd0);
    check("mid_rst_addr",   32'(bus0.mem_addr),     32'h0000);
    check("mid_rst_wdata",  bus0.mem_wdata,         32'd0);
    check("mid_rst_loaded", 32'(bus0.loaded_words), 32'd0);
    check("mid_rst_cpurst", 32'(bus0.cpu_reset),    32'd1);
    check("mid_rst_busy",   32'(bus0.busy),         32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    send(8'h07);
    send(8'h08);
    idle(3);
    check("mid_nwr_post", 32'(q0.size()), 32'd1);

    // Restart together with a byte: the 0x00 must be dropped, not taken as LEN_HI.
    q0.delete();
    @(negedge clk);
    restart  = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    send_frame(16'd1, {32'h0, 32'h0, 32'hAABBCCDD}, 1'b0);
    check("rs_nwr",  32'(q0.size()), 32'd1);
    if (q0.size() > 0) check("rs_data", q0[0].data, 32'hAABBCCDD);
    check("rs_done", 32'(bus0.done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
